// File: rtl/act_pkg.sv
// Shared types for the activation block: activation select encodings and FSM states.
package act_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    ACT_RELU  = 2'd0,
    ACT_CLAMP = 2'd1,
    ACT_LEAKY = 2'd2,
    ACT_PASS  = 2'd3
  } act_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_REQ = 3'd1,
    ST_RD_GAP = 3'd2,
    ST_WR_REQ = 3'd3,
    ST_WR_GAP = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/act_lane.sv
// One activation lane: applies RELU/CLAMP/LEAKY/PASS to a signed element and
// sign-extends the result to the bus width.
module act_lane
  import act_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned DATABUS_WIDTH = 32,
  parameter int unsigned LEAK_SHIFT    = 3
) (
  input  logic [DATA_WIDTH-1:0]    x,
  input  logic [MODE_W-1:0]        mode,
  input  logic [DATA_WIDTH-1:0]    clamp_max,
  output logic [DATABUS_WIDTH-1:0] y
);

  logic signed [DATA_WIDTH-1:0] xs;
  logic signed [DATA_WIDTH-1:0] cs;
  logic signed [DATA_WIDTH-1:0] r;

  assign xs = signed'(x);
  assign cs = signed'(clamp_max);

  always_comb begin
    r = xs;
    case (act_mode_t'(mode))
      ACT_RELU: begin
        if (xs[DATA_WIDTH-1]) r = '0;
      end
      // A non-positive bound leaves no legal output above zero.
      ACT_CLAMP: begin
        if (xs[DATA_WIDTH-1] || cs[DATA_WIDTH-1] || (cs == '0)) r = '0;
        else if (xs > cs) r = cs;
      end
      ACT_LEAKY: begin
        if (xs[DATA_WIDTH-1]) r = xs >>> LEAK_SHIFT;
      end
      default: r = xs;
    endcase
  end

  assign y = DATABUS_WIDTH'(r);

endmodule

// File: rtl/activation_with_mem.sv
// Streams a CHANNELS x HEIGHT x WIDTH tensor over the shared bus, one element
// at a time (read, turnaround, write), applying a runtime-selected activation.
module activation_with_mem
  import act_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned DATABUS_WIDTH = 32,
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned HEIGHT        = 4,
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned LEAK_SHIFT    = 3,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [MODE_W-1:0]     mode,
  input  logic [DATA_WIDTH-1:0] clamp_max,
  input  logic [ADDR_WIDTH-1:0] input_addr,
  input  logic [ADDR_WIDTH-1:0] output_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  mem_w,
  output logic                  mem_sel,
  inout  wire [ADDR_WIDTH-1:0]    address_bus,
  inout  wire [DATABUS_WIDTH-1:0] data_bus,
  input  logic                  ready
);

  localparam int unsigned N   = CHANNELS * HEIGHT * WIDTH;
  localparam int unsigned K_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned T_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);
  localparam logic [T_W-1:0] T_LAST = T_W'(TIMEOUT - 1);

  state_t                    state_q;
  logic [K_W-1:0]            k_q;
  logic [T_W-1:0]            wait_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [ADDR_WIDTH-1:0]     in_base_q;
  logic [ADDR_WIDTH-1:0]     out_base_q;
  logic [DATABUS_WIDTH-1:0]  data_q;
  logic [MODE_W-1:0]         mode_q;
  logic [DATA_WIDTH-1:0]     clamp_q;
  logic [DATABUS_WIDTH-1:0]  act_y;
  logic                      timed_out_c;
  logic                      unused_bus_hi;

  act_lane #(
    .DATA_WIDTH   (DATA_WIDTH),
    .DATABUS_WIDTH(DATABUS_WIDTH),
    .LEAK_SHIFT   (LEAK_SHIFT)
  ) u_lane (
    .x        (data_bus[DATA_WIDTH-1:0]),
    .mode     (mode_q),
    .clamp_max(clamp_q),
    .y        (act_y)
  );

  // Only the low element bits of a read word are consumed.
  assign unused_bus_hi = ^data_bus;

  assign timed_out_c = (TIMEOUT != 0) && (wait_q == T_LAST);

  // Bus enables decode straight from state so reset releases them at once.
  assign address_bus = ((state_q == ST_RD_REQ) || (state_q == ST_WR_REQ)) ? addr_q
                                                                         : {ADDR_WIDTH{1'bz}};
  assign data_bus    = (state_q == ST_WR_REQ) ? data_q : {DATABUS_WIDTH{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      wait_q     <= '0;
      addr_q     <= '0;
      in_base_q  <= '0;
      out_base_q <= '0;
      data_q     <= '0;
      mode_q     <= '0;
      clamp_q    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      mem_w      <= 1'b0;
      mem_sel    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_q     <= mode;
            clamp_q    <= clamp_max;
            in_base_q  <= input_addr;
            out_base_q <= output_addr;
            addr_q     <= input_addr;
            k_q        <= '0;
            wait_q     <= '0;
            error      <= 1'b0;
            busy       <= 1'b1;
            mem_sel    <= 1'b1;
            mem_w      <= 1'b0;
            state_q    <= ST_RD_REQ;
          end
        end
        ST_RD_REQ: begin
          if (ready) begin
            data_q  <= act_y;
            mem_sel <= 1'b0;
            state_q <= ST_RD_GAP;
          end else if (timed_out_c) begin
            error   <= 1'b1;
            mem_sel <= 1'b0;
            mem_w   <= 1'b0;
            done    <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            wait_q <= wait_q + T_W'(1);
          end
        end
        ST_RD_GAP: begin
          addr_q  <= out_base_q + ADDR_WIDTH'(k_q);
          wait_q  <= '0;
          mem_sel <= 1'b1;
          mem_w   <= 1'b1;
          state_q <= ST_WR_REQ;
        end
        ST_WR_REQ: begin
          if (ready) begin
            mem_sel <= 1'b0;
            mem_w   <= 1'b0;
            state_q <= ST_WR_GAP;
          end else if (timed_out_c) begin
            error   <= 1'b1;
            mem_sel <= 1'b0;
            mem_w   <= 1'b0;
            done    <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            wait_q <= wait_q + T_W'(1);
          end
        end
        ST_WR_GAP: begin
          if (k_q == K_LAST) begin
            done    <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            k_q     <= k_q + K_W'(1);
            addr_q  <= in_base_q + ADDR_WIDTH'(k_q) + ADDR_WIDTH'(1);
            wait_q  <= '0;
            mem_sel <= 1'b1;
            state_q <= ST_RD_REQ;
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          mem_sel <= 1'b0;
          mem_w   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_activation_with_mem.sv
// Directed bench for activation_with_mem: a behavioural bus memory with
// configurable ready delay, and one task per scenario.
module tb_activation_with_mem;

  localparam int unsigned TO = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  clamp_max = 8'd0;
  logic [7:0]  input_addr = 8'd0;
  logic [7:0]  output_addr = 8'd0;
  logic        busy, done, error, mem_w, mem_sel;
  logic        ready = 1'b0;
  wire  [7:0]  address_bus;
  wire  [31:0] data_bus;

  pullup pu_addr (address_bus);
  pullup pu_data (data_bus);

  logic [31:0] mem  [256];
  logic [31:0] wmem [256];
  int          wr_cnt [256];
  int          snap [256];
  int          ready_delay = 0;
  bit          no_ready = 1'b0;
  int          wcnt = 0;
  logic        tb_den = 1'b0;
  logic [31:0] tb_dq = '0;
  int          checks = 0;
  int          failures = 0;

  logic [7:0]  relu_in   [4] = '{8'hFD, 8'h05, 8'h80, 8'h7F};
  logic [31:0] relu_exp  [4] = '{32'h0, 32'h5, 32'h0, 32'h7F};
  logic [7:0]  leaky_in  [4] = '{8'h80, 8'hFF, 8'hF7, 8'h28};
  logic [31:0] leaky_exp [4] = '{32'hFFFFFFF0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h28};
  logic [7:0]  clamp_in  [4] = '{8'hFE, 8'h03, 8'h06, 8'h64};
  logic [31:0] clamp_exp [4] = '{32'h0, 32'h3, 32'h6, 32'h6};

  assign data_bus = tb_den ? tb_dq : 32'bz;

  activation_with_mem #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .clamp_max  (clamp_max),
    .input_addr (input_addr),
    .output_addr(output_addr),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .mem_w      (mem_w),
    .mem_sel    (mem_sel),
    .address_bus(address_bus),
    .data_bus   (data_bus),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  // Bus memory: answers each request after ready_delay idle cycles.
  always @(negedge clk) begin
    if (rst_n && mem_sel) begin
      tb_den <= !mem_w;
      tb_dq  <= mem[address_bus];
      if (!no_ready && wcnt >= ready_delay) begin
        ready <= 1'b1;
        wcnt  <= 0;
        if (mem_w) begin
          wmem[address_bus]   <= data_bus;
          wr_cnt[address_bus] <= wr_cnt[address_bus] + 1;
        end
      end else begin
        ready <= 1'b0;
        wcnt  <= wcnt + 1;
      end
    end else begin
      ready  <= 1'b0;
      tb_den <= 1'b0;
      wcnt   <= 0;
    end
  end

  task automatic launch(input logic [1:0] m, input logic [7:0] cm, input logic [7:0] ia,
                        input logic [7:0] oa, input int poke, output int done_cyc,
                        output int pulses, output logic err1);
    int cyc;
    @(negedge clk);
    mode = m; clamp_max = cm; input_addr = ia; output_addr = oa; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mode = ~m; clamp_max = 8'h55; input_addr = 8'h99; output_addr = 8'h99;
    err1 = error; cyc = 1; done_cyc = 0; pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      start = (cyc == poke);
      if (done) begin
        pulses++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (done_cyc != 0 && !done && !busy) break;
      @(posedge clk); #1; cyc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy, done, error, mem_w, mem_sel} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs got %b want 00000", {busy, done, error, mem_w, mem_sel});
    end
    checks++;
    if (address_bus !== 8'hFF || data_bus !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL reset_bus_release got addr=%h data=%h want released", address_bus, data_bus);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_relu();
    int dc, np; logic e1;
    for (int i = 0; i < 32; i++) mem[i] = {24'hA5A5A5, relu_in[i % 4]};
    snap = wr_cnt;
    launch(2'd0, 8'd0, 8'h00, 8'h40, 20, dc, np, e1);
    checks++;
    if (dc !== 129 || np !== 1) begin
      failures++;
      $display("FAIL relu_latency got cycle=%0d pulses=%0d want cycle=129 pulses=1", dc, np);
    end
    checks++;
    if (busy !== 1'b0 || error !== 1'b0) begin
      failures++;
      $display("FAIL relu_idle got busy=%b error=%b want 0 0", busy, error);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (wr_cnt[64+i] - snap[64+i] !== 1 || wmem[64+i] !== relu_exp[i % 4]) begin
        failures++;
        $display("FAIL relu_out[%0d] got %h (writes %0d) want %h", i, wmem[64+i],
                 wr_cnt[64+i] - snap[64+i], relu_exp[i % 4]);
      end
    end
    checks++;
    if (wr_cnt[96] - snap[96] !== 0) begin
      failures++;
      $display("FAIL relu_no_overrun got %0d writes at 0x60 want 0", wr_cnt[96] - snap[96]);
    end
  endtask

  task automatic test_leaky();
    int dc, np; logic e1;
    for (int i = 0; i < 32; i++) mem[128+i] = (i < 4) ? {24'h0, leaky_in[i]} : 32'h0;
    snap = wr_cnt;
    launch(2'd2, 8'd0, 8'h80, 8'hC0, 0, dc, np, e1);
    checks++;
    if (dc !== 129) begin
      failures++;
      $display("FAIL leaky_latency got %0d want 129", dc);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_cnt[192+i] - snap[192+i] !== 1 || wmem[192+i] !== leaky_exp[i]) begin
        failures++;
        $display("FAIL leaky_out[%0d] got %h want %h", i, wmem[192+i], leaky_exp[i]);
      end
    end
  endtask

  task automatic test_clamp();
    int dc, np; logic e1;
    for (int i = 0; i < 32; i++) mem[128+i] = (i < 4) ? {24'h0, clamp_in[i]} : 32'h0;
    snap = wr_cnt;
    launch(2'd1, 8'd6, 8'h80, 8'hC0, 0, dc, np, e1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_cnt[192+i] - snap[192+i] !== 1 || wmem[192+i] !== clamp_exp[i]) begin
        failures++;
        $display("FAIL clamp6_out[%0d] got %h want %h", i, wmem[192+i], clamp_exp[i]);
      end
    end
    snap = wr_cnt;
    launch(2'd1, 8'hFB, 8'h80, 8'hC0, 0, dc, np, e1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_cnt[192+i] - snap[192+i] !== 1 || wmem[192+i] !== 32'h0) begin
        failures++;
        $display("FAIL clamp_neg_out[%0d] got %h want 00000000", i, wmem[192+i]);
      end
    end
  endtask

  task automatic test_inplace_wrap();
    int dc, np; logic e1;
    logic [7:0] v;
    for (int i = 0; i < 32; i++) begin
      v = 8'(i * 9 - 100);
      mem[(240 + i) % 256] = {{24{v[7]}}, v};
    end
    snap = wr_cnt;
    ready_delay = 3;
    launch(2'd3, 8'd0, 8'hF0, 8'hF0, 0, dc, np, e1);
    ready_delay = 0;
    checks++;
    if (dc !== 321 || np !== 1) begin
      failures++;
      $display("FAIL inplace_latency got cycle=%0d pulses=%0d want cycle=321 pulses=1", dc, np);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (wmem[(240 + i) % 256] !== mem[(240 + i) % 256]) begin
        failures++;
        $display("FAIL inplace_out[%0d] got %h want %h", i, wmem[(240 + i) % 256],
                 mem[(240 + i) % 256]);
      end
    end
    checks++;
    if (wr_cnt[0] - snap[0] !== 1 || wr_cnt[255] - snap[255] !== 1 || wr_cnt[16] - snap[16] !== 0) begin
      failures++;
      $display("FAIL inplace_wrap got writes 0xFF=%0d 0x00=%0d 0x10=%0d want 1 1 0",
               wr_cnt[255] - snap[255], wr_cnt[0] - snap[0], wr_cnt[16] - snap[16]);
    end
  endtask

  task automatic test_timeout();
    int dc, np; logic e1;
    snap = wr_cnt;
    no_ready = 1'b1;
    launch(2'd0, 8'd0, 8'h20, 8'h60, 0, dc, np, e1);
    no_ready = 1'b0;
    checks++;
    if (dc !== TO + 1 || np !== 1) begin
      failures++;
      $display("FAIL timeout_latency got cycle=%0d pulses=%0d want cycle=%0d pulses=1", dc, np, TO + 1);
    end
    checks++;
    if (error !== 1'b1 || mem_sel !== 1'b0 || mem_w !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_flags got error=%b sel=%b w=%b busy=%b want 1 0 0 0",
               error, mem_sel, mem_w, busy);
    end
    checks++;
    if (address_bus !== 8'hFF || data_bus !== 32'hFFFFFFFF || wr_cnt[96] - snap[96] !== 0) begin
      failures++;
      $display("FAIL timeout_bus got addr=%h data=%h want released, no write", address_bus, data_bus);
    end
    @(posedge clk); #1;
    checks++;
    if (error !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky got error=%b want 1", error);
    end
    launch(2'd0, 8'd0, 8'h20, 8'h60, 0, dc, np, e1);
    checks++;
    if (e1 !== 1'b0 || dc !== 129 || error !== 1'b0) begin
      failures++;
      $display("FAIL timeout_relaunch got err_at_start=%b cycle=%0d error=%b want 0 129 0", e1, dc, error);
    end
  endtask

  task automatic test_reset_mid_write();
    bit found = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = {24'h0, relu_in[i % 4]};
    snap = wr_cnt;
    ready_delay = 3;
    @(negedge clk);
    mode = 2'd0; input_addr = 8'h00; output_addr = 8'h40; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mem_sel && mem_w) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!found || address_bus !== 8'h40 || data_bus !== 32'h0) begin
      failures++;
      $display("FAIL midwr_drive got found=%b addr=%h data=%h want 1 40 00000000", found, address_bus, data_bus);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, mem_sel, mem_w, done} !== 4'b0 || address_bus !== 8'hFF || data_bus !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL midwr_reset got busy/sel/w/done=%b addr=%h data=%h want 0000 released",
               {busy, mem_sel, mem_w, done}, address_bus, data_bus);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ready_delay = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || mem_sel !== 1'b0 || wr_cnt[64] - snap[64] !== 0) begin
      failures++;
      $display("FAIL midwr_after got busy=%b sel=%b writes=%0d want 0 0 0", busy, mem_sel,
               wr_cnt[64] - snap[64]);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h0;
      snap[i] = 0;
    end
    test_reset();
    test_relu();
    test_leaky();
    test_clamp();
    test_inplace_wrap();
    test_timeout();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/activation_with_mem.md
Name: activation_with_mem

Overview:
- Parametrised successor to the fixed-ReLU memory block. Streams a CHANNELS×HEIGHT×WIDTH tensor from shared memory, applies a runtime-selected activation, and writes each result back.
- Works one element at a time as read→compute→write, with no full-matrix buffer. In-place operation is legal.
- Sits between the conv/pool engines on the shared address/data bus.
- Adds the following over the previous block:
  - a ready-timeout with an error flag;
  - a single-cycle done pulse;
  - a return to IDLE for re-launch.

Parameters:
- DATA_WIDTH, 8, signed element width.
- ADDR_WIDTH, 8, memory address width; addresses wrap modulo 2^ADDR_WIDTH.
- DATABUS_WIDTH, 32, data bus width; must be ≥ DATA_WIDTH.
- CHANNELS, 2, number of channel planes.
- HEIGHT, 4, rows per plane.
- WIDTH, 4, columns per plane.
- LEAK_SHIFT, 3, arithmetic right shift applied to negative inputs in LEAKY mode.
- TIMEOUT, 255, maximum wait cycles for ready per access; 0 disables the timeout.

Ports:
- clk  in  1  Single clock.
- rst_n  in  1  Reset; asynchronous, active-low.
- start  in  1  Launch request; sampled in IDLE only.
- mode  in  2  Activation select: 0 RELU, 1 CLAMP, 2 LEAKY, 3 PASS. Latched at start.
- clamp_max  in  DATA_WIDTH  Signed upper bound for CLAMP. Latched at start.
- input_addr  in  ADDR_WIDTH  Base address of the source tensor. Latched at start.
- output_addr  in  ADDR_WIDTH  Base address of the destination tensor. Latched at start.
- busy  out  1  High in every state except IDLE.
- done  out  1  One-cycle completion pulse.
- error  out  1  Sticky timeout flag; cleared at the next accepted start.
- mem_w  out  1  1 = write, 0 = read.
- mem_sel  out  1  Memory access request.
- address_bus  inout  ADDR_WIDTH  Driven in RD_REQ and WR_REQ only; otherwise Z.
- data_bus  inout  DATABUS_WIDTH  Driven in WR_REQ only; otherwise Z.
- ready  in  1  Memory completion strobe for the current access.

Behaviour:
- Reset (async on rst_n low):
  - state = IDLE; busy, done, error, mem_w, mem_sel = 0.
  - Element counter, address and data registers = 0.
  - Both buses release to Z immediately, because bus enables decode combinationally from state.
- Element count N = CHANNELS*HEIGHT*WIDTH. Element k reads input_addr+k and writes output_addr+k, in raster order: channel, then row, then column.
- IDLE:
  - start=1 latches mode, clamp_max and both addresses; clears error and k; sets mem_sel=1, mem_w=0; goes to RD_REQ.
  - start asserted in any other state is ignored.
- RD_REQ:
  - Drives address, mem_sel=1, mem_w=0.
  - On ready: capture data_bus[DATA_WIDTH-1:0], compute the result into the data register, set mem_sel=0, go to RD_GAP.
- RD_GAP: one bus-turnaround cycle. Load address=output_addr+k; set mem_sel=1, mem_w=1; go to WR_REQ.
- WR_REQ:
  - Drives address and data.
  - On ready: set mem_sel=0, mem_w=0, go to WR_GAP.
- WR_GAP:
  - If k==N-1, go to DONE.
  - Otherwise: k++, address=input_addr+k+1, mem_sel=1, go to RD_REQ.
- DONE: done=1 for exactly this cycle, then IDLE. done is registered.
- Latency with ready asserted on the first request cycle:
  - 4 cycles per element.
  - done is high on cycle 4N+1 after the start sample edge; 129 cycles for the default parameters.
- Timeout:
  - A wait counter resets on entry to each REQ state and increments every cycle without ready.
  - When it reaches TIMEOUT: error=1, mem_sel=0, mem_w=0, go to DONE (done still pulses).
  - TIMEOUT=0 never expires.
- Activation arithmetic (signed DATA_WIDTH input x):
  - RELU: x<0 → 0, else x.
  - CLAMP: x<0 → 0; x>clamp_max → clamp_max; else x. If clamp_max≤0 the output is 0.
  - LEAKY: x<0 → x>>>LEAK_SHIFT (floor toward -∞), else x.
  - PASS: x.
  - The result is sign-extended to DATABUS_WIDTH.
- Boundaries:
  - Address overflow wraps.
  - input_addr==output_addr is legal, since each element is read before its write.
  - The most negative value in LEAKY stays negative (-128>>>3 = -16).
  - ready outside a REQ state is ignored.

Decomposition:
- act_pkg holds:
  - the act_mode_t enum (RELU, CLAMP, LEAKY, PASS);
  - the state_t enum (IDLE, RD_REQ, RD_GAP, WR_REQ, WR_GAP, DONE);
  - the mode encodings.
- One combinational sub-module, act_lane (parameters DATA_WIDTH, DATABUS_WIDTH, LEAK_SHIFT; inputs x, mode, clamp_max; output y sign-extended). It is reusable by future vector versions.
- Everything else stays in activation_with_mem: FSM, counters, bus drivers.

Test Plan:
- Defaults, RELU, ready=1 always, input_addr=0x00 holding -3, 5, -128, 127, … → output_addr=0x40 holds 0, 5, 0, 127, …. done pulses once, 129 cycles after start; busy is low afterwards.
- LEAKY, LEAK_SHIFT=3, inputs -128, -1, -9, 40 → outputs 0xFFFFFFF0 (-16), 0xFFFFFFFF (-1), 0xFFFFFFFE (-2), 0x00000028.
- CLAMP, clamp_max=6, inputs -2, 3, 6, 100 → 0, 3, 6, 6. Repeat with clamp_max=-5 → all outputs 0.
- In-place PASS with input_addr=output_addr=0xF0, plus ready delayed 3 cycles per access → data unchanged, addresses wrap 0xFF→0x00 after 16 elements, done at 4N+1+6N cycles.
- TIMEOUT=10, ready stuck low → exactly 10 wait cycles, then error=1 and a done pulse, with both buses Z. The next start clears error and the run completes.
- rst_n pulsed low mid-WR_REQ → mem_sel, mem_w, busy go 0 and the buses go Z immediately. start while busy is ignored: the run length is unchanged.
